serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_sub.sv | 17 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: a - b - bin.
// Produces the difference bit and the outgoing borrow.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first, one bit per cycle.
// Valid/ready on both sides; result held until consumed.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [CW-1:0] cnt;
    logic          br;
    logic          xm;
    logic          ym;
    logic          diff;
    logic          br_nx;
    logic          accept;
    logic          last;

    full_sub u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (diff),
        .bout (br_nx)
    );

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (cnt == CW'(W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            xm     <= 1'b0;
            ym     <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= x;
            b_sr   <= y;
            xm     <= x[W-1];
            ym     <= y[W-1];
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {diff, res_sr[W-1:1]};
            br     <= br_nx;
            cnt    <= cnt + 1'b1;
            if (last) begin
                d    <= {diff, res_sr[W-1:1]};
                bout <= br_nx;
                ovf  <= (xm != ym) && (diff != xm);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (W=3).
// Reference results come from plain integer arithmetic.
module tb_serial_subtractor;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: unsigned modular difference, unsigned borrow,
    // signed range overflow.
    task automatic model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         output logic [W-1:0] ed, output logic eb,
                         output logic eo);
        int ux;
        int uy;
        int sx;
        int sy;
        int sd;
        int md;
        ux = int'(xv);
        uy = int'(yv);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        sd = sx - sy;
        md = (ux - uy + (1 << W)) % (1 << W);
        ed = W'(md);
        eb = (ux < uy);
        eo = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endtask

    // One full transaction; stall = cycles of out_ready low in DONE.
    task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input int stall);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           lat;
        model(xv, yv, ed, eb, eo);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid  = 1'b1;
        x         = xv;
        y         = yv;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), W);
        check("d", 32'(d), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
        check("ovf", 32'(ovf), 32'(eo));
        if (stall > 0) begin
            in_valid = 1'b1;
            x        = ~xv;
            y        = yv + 3'd1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", 32'(out_valid), 1);
                check("stall_ready", 32'(in_ready), 0);
                check("stall_d", 32'(d), 32'(ed));
                check("stall_bout", 32'(bout), 32'(eb));
                check("stall_ovf", 32'(ovf), 32'(eo));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 0);
        check("post_hs_ready", 32'(in_ready), 1);
        check("post_hs_d", 32'(d), 32'(ed));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_d", 32'(d), 0);
        check("rst_bout", 32'(bout), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd5, 3'd2, 0);
        do_op(3'd0, 3'd7, 0);
        do_op(3'd3, 3'd4, 1);
        do_op(3'd6, 3'd6, 5);

        // Reset during the second RUN cycle
        @(negedge clk);
        in_valid = 1'b1;
        x        = 3'd5;
        y        = 3'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_d", 32'(d), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(out_valid), 0);
        end
        rst_n = 1'b1;
        do_op(3'd7, 3'd1, 0);

        // Exhaustive sweep with random back-pressure
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                do_op(W'(i), W'(j), int'($urandom_range(0, 2)));
            end
        end

        // Random extra operations
        for (int k = 0; k < 20; k++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
